// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the core's MEM stage.
// Holds DEPTH x 64-bit doublewords, accepts one load/store at a time, waits
// LATENCY cycles and returns extended read data or store completion.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_write, req_addr,
//   req_wdata, req_size           store flag, byte address, store data, funct3 size
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          extended load data (0 on store/error), error flag

// One byte lane of the store merge: take the new byte when the lane is enabled.
module dmem_lane (
  input  logic       en,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] out_byte
);
  assign out_byte = en ? new_byte : old_byte;
endmodule

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int          ADDR_BITS = $clog2(DEPTH);
  localparam int          NUM_LANES = 8;
  localparam logic [3:0]  LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;

  logic [63:0] mem_q [DEPTH];
  logic        mem_we;

  // Access decode, all from the latched request.
  logic [ADDR_BITS-1:0] idx;
  logic [2:0]           off;
  logic [63:0]          rd_word, shifted, load_val, wdata_sh, merged;
  logic [NUM_LANES-1:0] be_base, byte_en;
  logic                 oor, misalign, illegal, err;

  assign idx      = addr_q[ADDR_BITS+2:3];
  assign off      = addr_q[2:0];
  assign rd_word  = mem_q[idx];
  assign oor      = |addr_q[63:ADDR_BITS+3];
  assign illegal  = (size_q == 3'b111) || (write_q && size_q[2]);
  assign err      = oor || misalign || illegal;
  assign shifted  = rd_word >> {off, 3'b000};
  assign wdata_sh = wdata_q << {off, 3'b000};
  assign byte_en  = be_base << off;

  always_comb begin
    misalign = 1'b0;
    be_base  = 8'hFF;
    load_val = shifted;
    case (size_q[1:0])
      2'b00: begin
        be_base  = 8'h01;
        load_val = size_q[2] ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        misalign = off[0];
        be_base  = 8'h03;
        load_val = size_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        misalign = |off[1:0];
        be_base  = 8'h0F;
        load_val = size_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        misalign = |off;
      end
    endcase
  end

  // Read-modify-write merge, one instance per byte lane.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_lane u_lane (
      .en       (byte_en[g]),
      .old_byte (rd_word[8*g +: 8]),
      .new_byte (wdata_sh[8*g +: 8]),
      .out_byte (merged[8*g +: 8])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        // req_ready_q stays low for the first cycle out of reset.
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = LAT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we       = write_q && !err;
          resp_err_d   = err;
          resp_rdata_d = (err || write_q) ? 64'd0 : load_val;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered images of the next state.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
    end
  end

  // RAM is cleared by reset and written only on the BUSY->RESP edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= merged;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=256, LATENCY=2).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // One full transaction with resp_ready high. lat = edges from accept to
  // resp_valid; 99 if never accepted, 50 if the response never came.
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [2:0] s, output logic [63:0] rd, output logic e,
                      output int lat);
    int n;
    req_write = w; req_addr = a; req_wdata = d; req_size = s; req_valid = 1'b1;
    rd = '0; e = 1'b0; lat = 99;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched request must not care.
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_size = ~s;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; e = resp_err;
    if (resp_valid === 1'b1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    req_valid = 1'b1; req_addr = 64'h10; req_size = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 64'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ready_pre_edge: got %b want 0", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_post_edge: got %b want 1", req_ready); end
  endtask

  task automatic test_store_load;
    logic [63:0] rd; logic e; int lat;
    xact(1'b1, 64'h10, 64'h1122334455667788, 3'd3, rd, e, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sd_lat: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sd_err: got %b want 0", e); end
    n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL sd_rdata: got %h want 0", rd); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    xact(1'b0, 64'h10, 64'd0, 3'd3, rd, e, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ld_lat: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL ld_err: got %b want 0", e); end
    n_cmp++; if (rd !== 64'h1122334455667788) begin n_bad++; $display("FAIL ld_rdata: got %h want 1122334455667788", rd); end
  endtask

  task automatic test_subword;
    logic [63:0] rd; logic e; int lat;
    logic [2:0]  sz  [9] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd3, 3'd1, 3'd5, 3'd2, 3'd6};
    logic [63:0] ad  [9] = '{64'h17, 64'h10, 64'h10, 64'h10, 64'h10, 64'h16, 64'h12, 64'h1C, 64'h1C};
    logic        wr  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] wd  [9] = '{64'd0, 64'hDEADBEEFCAFEBA80, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                             64'h1234567880000001, 64'd0};
    logic [63:0] exp [9] = '{64'h11, 64'd0, 64'hFFFFFFFFFFFFFF80, 64'h80, 64'h1122334455667780,
                             64'h1122, 64'h5566, 64'd0, 64'h80000001};
    for (int i = 0; i < 9; i++) begin
      xact(wr[i], ad[i], wd[i], sz[i], rd, e, lat);
      n_cmp++; if (rd !== exp[i] || e !== 1'b0) begin n_bad++; $display("FAIL sub_%0d: got %h err %b want %h err 0", i, rd, e, exp[i]); end
    end
    xact(1'b0, 64'h1C, 64'd0, 3'd2, rd, e, lat);
    n_cmp++; if (rd !== 64'hFFFFFFFF80000001) begin n_bad++; $display("FAIL lw_sext: got %h want ffffffff80000001", rd); end
    xact(1'b0, 64'h18, 64'd0, 3'd3, rd, e, lat);
    n_cmp++; if (rd !== 64'h8000000100000000) begin n_bad++; $display("FAIL sw_merge: got %h want 8000000100000000", rd); end
  endtask

  task automatic test_errors;
    logic [63:0] rd; logic e; int lat;
    logic        wr [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] ad [6] = '{64'h13, 64'h800, 64'h800, 64'h10, 64'h10, 64'h12};
    logic [63:0] wd [6] = '{64'hBEEF, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFF, 64'd0, 64'd0};
    logic [2:0]  sz [6] = '{3'd1, 3'd3, 3'd3, 3'd4, 3'd7, 3'd2};
    for (int i = 0; i < 6; i++) begin
      xact(wr[i], ad[i], wd[i], sz[i], rd, e, lat);
      n_cmp++; if (e !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL err_%0d: got err %b rdata %h want err 1 rdata 0", i, e, rd); end
    end
    xact(1'b0, 64'h10, 64'd0, 3'd3, rd, e, lat);
    n_cmp++; if (rd !== 64'h1122334455667780 || e !== 1'b0) begin n_bad++; $display("FAIL err_nowrite: got %h want 1122334455667780", rd); end
    xact(1'b0, 64'h0, 64'd0, 3'd3, rd, e, lat);
    n_cmp++; if (rd !== 64'd0 || e !== 1'b0) begin n_bad++; $display("FAIL err_nowrap: got %h want 0", rd); end
  endtask

  task automatic test_backpressure;
    int n;
    resp_ready = 1'b0;
    req_write = 1'b0; req_addr = 64'h10; req_size = 3'd3; req_wdata = '0; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // Next request presented immediately and held.
    req_addr = 64'h17; req_size = 3'd4;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL bp_lat: got %0d want 3", n); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122334455667780 || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold_%0d: got v %b d %h rdy %b want v 1 d 1122334455667780 rdy 0", i, resp_valid, resp_rdata, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got v %b rdy %b want v 0 rdy 1", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 3 || resp_rdata !== 64'h11 || resp_err !== 1'b0) begin n_bad++; $display("FAIL bp_pending: got lat %0d d %h want lat 3 d 11", n, resp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; logic e; int lat; int n;
    req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hAB; req_size = 3'd0; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_out: got rdy %b v %b d %h e %b want all 0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_noresp: got %b want 0", resp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 64'h20, 64'd0, 3'd3, rd, e, lat);
    n_cmp++; if (rd !== 64'd0 || e !== 1'b0 || lat !== 3) begin n_bad++; $display("FAIL mid_rst_ld20: got %h err %b lat %0d want 0 0 3", rd, e, lat); end
    xact(1'b0, 64'h10, 64'd0, 3'd3, rd, e, lat);
    n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL mid_rst_cleared: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1);
  end
endmodule
